// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the SRAM bridge.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WDONE,
    ST_RWAIT,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } dphase_e;

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator: derives lane enables from HSIZE and the
// in-word address offset, and flags oversize or misaligned transfers.
module ahb_strb_gen #(
  parameter  int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [2:0]    hsize_i,
  input  logic [LB-1:0] addr_lo_i,
  output logic [NB-1:0] strb_o,
  output logic          err_o
);

  int unsigned sz;
  int unsigned off;

  always_comb begin
    sz     = 32'(hsize_i);
    off    = 32'(addr_lo_i);
    err_o  = (sz > 32'(LB)) || ((off & ((32'd1 << sz) - 32'd1)) != 32'd0);
    strb_o = '0;
    // Contiguous run of 2**HSIZE lanes starting at the byte offset.
    for (int unsigned b = 0; b < 32'(NB); b++)
      strb_o[b] = (b >= off) && (b < off + (32'd1 << sz));
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave front-end for a single-port synchronous SRAM macro:
// one data-phase FSM, byte-lane writes, RD_LAT-cycle reads, two-cycle ERROR.
module ahb_sram_bridge
  import ahb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic              HREADYIN,
  input  logic [AW-1:0]     HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DW-1:0]     HWDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [DW-1:0]     HRDATA,
  output logic              o_we,
  output logic [MEM_AW-1:0] o_waddr,
  output logic [DW/8-1:0]   o_wstrb,
  output logic [DW-1:0]     o_wdata,
  output logic              o_re,
  output logic [MEM_AW-1:0] o_raddr,
  input  logic [DW-1:0]     i_rdata
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);

  dphase_e           state_q, state_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;

  logic [NB-1:0]     strb;
  logic              size_err, hi_err, illegal;
  logic              acc, valid_rd, conflict, ready;
  logic [MEM_AW-1:0] widx;
  logic              unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  ahb_strb_gen #(.DW(DW)) u_strb (
    .hsize_i   (HSIZE),
    .addr_lo_i (HADDR[LB-1:0]),
    .strb_o    (strb),
    .err_o     (size_err)
  );

  assign widx = HADDR[MEM_AW+LB-1:LB];

  generate
    if (AW > MEM_AW + LB) begin : g_hi
      assign hi_err = |HADDR[AW-1:MEM_AW+LB];
    end else begin : g_nohi
      assign hi_err = 1'b0;
    end
  endgenerate

  assign illegal = size_err | hi_err;

  // Conflict detection ignores HREADYIN: during our own data phase it mirrors
  // HREADYOUT, and including it would close a combinational loop.
  assign valid_rd = HSEL & HTRANS[1] & ~HWRITE & ~illegal;
  assign acc      = HSEL & HTRANS[1] & HREADYIN & ready;

  always_comb begin
    ready    = 1'b1;
    HRESP    = HRESP_OKAY;
    HRDATA   = '0;
    conflict = 1'b0;
    case (state_q)
      ST_WR: begin
        conflict = valid_rd && (widx == waddr_q);
        ready    = ~conflict;
      end
      ST_RWAIT: ready = 1'b0;
      ST_RD:    HRDATA = i_rdata;
      ST_ERR1: begin
        ready = 1'b0;
        HRESP = HRESP_ERROR;
      end
      ST_ERR2:  HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign HREADYOUT = ready;

  always_comb begin
    state_d = ST_IDLE;
    waddr_d = waddr_q;
    wstrb_d = wstrb_q;
    if (!ready) begin
      case (state_q)
        ST_WR:    state_d = ST_WDONE;
        ST_RWAIT: state_d = ST_RD;
        ST_ERR1:  state_d = ST_ERR2;
        default:  state_d = ST_IDLE;
      endcase
    end else if (acc) begin
      if (illegal) begin
        state_d = ST_ERR1;
      end else if (HWRITE) begin
        state_d = ST_WR;
        waddr_d = widx;
        wstrb_d = strb;
      end else begin
        state_d = (RD_LAT == 2) ? ST_RWAIT : ST_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Strobes are gated by rst so a write in flight at reset never lands.
  assign o_we    = (state_q == ST_WR) & ~rst;
  assign o_waddr = waddr_q;
  assign o_wstrb = wstrb_q;
  assign o_wdata = HWDATA;
  assign o_re    = acc & ~HWRITE & ~illegal & ~conflict & ~rst;
  assign o_raddr = widx;

endmodule
